// File: rtl/chacha_keystream_xor.sv
// ChaCha keystream XOR engine: fetches 16-word keystream blocks from an external
// block function and XORs them onto a plaintext word stream, one word per cycle.
module chacha_keystream_xor (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [31:0]            counter_init,
  output logic                   block_req,
  output logic [31:0]            block_counter,
  input  logic                   block_valid,
  input  logic [3:0][3:0][31:0]  MatrixOut,
  input  logic                   pt_valid,
  output logic                   pt_ready,
  input  logic [31:0]            pt_data,
  input  logic                   pt_last,
  output logic                   ct_valid,
  input  logic                   ct_ready,
  output logic [31:0]            ct_data,
  output logic                   ct_last,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT_BLK,
    S_STREAM,
    S_DRAIN
  } state_t;

  state_t             state_q;
  logic [15:0][31:0]  ks_q;
  logic [3:0]         idx_q;
  logic [31:0]        counter_q;
  logic               block_req_q;
  logic               ct_valid_q;
  logic [31:0]        ct_data_q;
  logic               ct_last_q;
  logic               busy_q;
  logic               done_q;
  logic               err_q;

  logic               pt_fire;

  // A new word may enter whenever the output register is empty or draining this cycle.
  assign pt_ready = (state_q == S_STREAM) && (!ct_valid_q || ct_ready);
  assign pt_fire  = pt_valid && pt_ready;

  assign block_req     = block_req_q;
  assign block_counter = counter_q;
  assign ct_valid      = ct_valid_q;
  assign ct_data       = ct_data_q;
  assign ct_last       = ct_last_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the keystream buffer sits in the reset branch on purpose, so no key
      // material from an aborted message survives a reset.
      state_q     <= S_IDLE;
      ks_q        <= '0;
      idx_q       <= '0;
      counter_q   <= '0;
      block_req_q <= 1'b0;
      ct_valid_q  <= 1'b0;
      ct_data_q   <= '0;
      ct_last_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;

      // NOTE: with non-blocking assignments the later statement wins, so a new word
      // accepted in the same cycle as a handshake keeps ct_valid high.
      if (ct_valid_q && ct_ready) ct_valid_q <= 1'b0;

      if (pt_fire) begin
        ct_valid_q <= 1'b1;
        ct_data_q  <= pt_data ^ ks_q[idx_q];
        ct_last_q  <= pt_last;
        idx_q      <= idx_q + 4'd1;
      end

      case (state_q)
        S_IDLE: begin
          if (start) begin
            counter_q   <= counter_init;
            err_q       <= 1'b0;
            busy_q      <= 1'b1;
            block_req_q <= 1'b1;
            state_q     <= S_REQ;
          end
        end
        S_REQ: state_q <= S_WAIT_BLK;
        S_WAIT_BLK: begin
          // Packed layout puts MatrixOut[row][col] at word 4*row+col of the buffer.
          if (block_valid) begin
            ks_q        <= MatrixOut;
            idx_q       <= '0;
            block_req_q <= 1'b0;
            state_q     <= S_STREAM;
          end
        end
        S_STREAM: begin
          if (pt_fire) begin
            if (pt_last) begin
              state_q <= S_DRAIN;
            end else if (idx_q == 4'hF) begin
              if (counter_q == 32'hFFFF_FFFF) begin
                err_q   <= 1'b1;
                state_q <= S_DRAIN;
              end else begin
                counter_q   <= counter_q + 32'd1;
                block_req_q <= 1'b1;
                state_q     <= S_REQ;
              end
            end
          end
        end
        S_DRAIN: begin
          if (!ct_valid_q) begin
            busy_q  <= 1'b0;
            done_q  <= !err_q;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
